// File: rtl/fifo_wr_ctrl_gray.sv
// Write-side controller for a dual-clock FIFO: binary/Gray write pointer, read-pointer synchronizer,
// registered full/almost-full/level flags. Define FIFO_WR_OVERFLOW_EN for a sticky overflow flag and reject counter.
module fifo_wr_ctrl_gray #(
  parameter int ADDR_W       = 3,
  parameter int AFULL_THRESH = 6,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [ADDR_W:0]   rptr_gray,
  output logic              write_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              woverflow
);

  generate
    if (ADDR_W < 2 || ADDR_W > 12 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDR_W)) begin : g_bad_param
      $error("fifo_wr_ctrl_gray: parameter out of legal range");
    end
  endgenerate

  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_THRESH);

  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rq_gray;
  logic [ADDR_W:0] rq_bin;
  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] full_gray;
  logic [ADDR_W:0] level_next;

  // Read pointer crosses into this domain only through the flop chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    rq_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) rq_bin[i] = ^(rq_gray >> i);
  end

  assign write_en   = winc & ~wfull;
  assign wbin_next  = wbin + {{ADDR_W{1'b0}}, write_en};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  // Full when the pointers differ only in the wrap bit, i.e. top two Gray bits inverted
  assign full_gray  = {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]};
  assign level_next = wbin_next - rq_bin;
  assign waddr      = wbin[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= (wgray_next == full_gray);
      walmost_full <= (level_next >= AFULL_LVL);
      wlevel       <= level_next;
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  logic [7:0] wovf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      woverflow <= 1'b0;
      wovf_cnt  <= '0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
      if (wovf_cnt != 8'hFF) wovf_cnt <= wovf_cnt + 8'd1;
    end
  end
`else
  assign woverflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl_gray.sv
// Self-checking bench for fifo_wr_ctrl_gray: table of directed vectors plus hand-written
// wrap, async-reset and small-depth sequences.
module tb_fifo_wr_ctrl_gray;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [3:0] rptr_gray;
  logic       write_en;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  logic       winc2;
  logic [2:0] rptr_gray2;
  logic       write_en2;
  logic [1:0] waddr2;
  logic [2:0] wptr_gray2;
  logic       wfull2;
  logic       walmost_full2;
  logic [2:0] wlevel2;
  logic       woverflow2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_ctrl_gray #(.ADDR_W(3), .AFULL_THRESH(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .winc(winc), .rptr_gray(rptr_gray),
    .write_en(write_en), .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  fifo_wr_ctrl_gray #(.ADDR_W(2), .AFULL_THRESH(1), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .winc(winc2), .rptr_gray(rptr_gray2),
    .write_en(write_en2), .waddr(waddr2), .wptr_gray(wptr_gray2), .wfull(wfull2),
    .walmost_full(walmost_full2), .wlevel(wlevel2), .woverflow(woverflow2)
  );

  typedef struct {
    logic       winc;
    logic [3:0] rptr;
    logic       we;
    logic [2:0] waddr;
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic [3:0] level;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] to_bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; winc = 1'b0; winc2 = 1'b0; rptr_gray = '0; rptr_gray2 = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One vector: drive at negedge, check combinational strobe, then registered state after the edge
  task automatic apply_stimulus(input vec_t v, input int idx);
    @(negedge clk);
    winc = v.winc;
    rptr_gray = v.rptr;
    #1;
    check_output($sformatf("vec%0d write_en", idx), write_en, v.we);
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d waddr", idx), waddr, v.waddr);
    check_output($sformatf("vec%0d wptr_gray", idx), wptr_gray, v.gray);
    check_output($sformatf("vec%0d wfull", idx), wfull, v.full);
    check_output($sformatf("vec%0d walmost_full", idx), walmost_full, v.afull);
    check_output($sformatf("vec%0d wlevel", idx), wlevel, v.level);
  endtask

  initial begin
    logic [3:0] s0, s1, mwbin, rqb, exp_lvl, prev_gray, rptr_v;
    int         wr_total;

    // fill to full, three rejected writes, read advance to 2, one more write
    vecs[0]  = '{1'b1, 4'h0, 1'b1, 3'd1, 4'h1, 1'b0, 1'b0, 4'd1};
    vecs[1]  = '{1'b1, 4'h0, 1'b1, 3'd2, 4'h3, 1'b0, 1'b0, 4'd2};
    vecs[2]  = '{1'b1, 4'h0, 1'b1, 3'd3, 4'h2, 1'b0, 1'b0, 4'd3};
    vecs[3]  = '{1'b1, 4'h0, 1'b1, 3'd4, 4'h6, 1'b0, 1'b0, 4'd4};
    vecs[4]  = '{1'b1, 4'h0, 1'b1, 3'd5, 4'h7, 1'b0, 1'b0, 4'd5};
    vecs[5]  = '{1'b1, 4'h0, 1'b1, 3'd6, 4'h5, 1'b0, 1'b1, 4'd6};
    vecs[6]  = '{1'b1, 4'h0, 1'b1, 3'd7, 4'h4, 1'b0, 1'b1, 4'd7};
    vecs[7]  = '{1'b1, 4'h0, 1'b1, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8};
    vecs[8]  = '{1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8};
    vecs[9]  = '{1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8};
    vecs[10] = '{1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8};
    vecs[11] = '{1'b0, 4'h3, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8};
    vecs[12] = '{1'b0, 4'h3, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8};
    vecs[13] = '{1'b0, 4'h3, 1'b0, 3'd0, 4'hC, 1'b0, 1'b1, 4'd6};
    vecs[14] = '{1'b1, 4'h3, 1'b1, 3'd1, 4'hD, 1'b0, 1'b1, 4'd7};
    vecs[15] = '{1'b0, 4'h3, 1'b0, 3'd1, 4'hD, 1'b0, 1'b1, 4'd7};

    rst = 1'b0; winc = 1'b0; winc2 = 1'b0; rptr_gray = '0; rptr_gray2 = '0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset waddr", waddr, 0);
    check_output("reset wptr_gray", wptr_gray, 0);
    check_output("reset wfull", wfull, 0);
    check_output("reset walmost_full", walmost_full, 0);
    check_output("reset wlevel", wlevel, 0);
    check_output("reset woverflow", woverflow, 0);
    check_output("reset write_en", write_en, 0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) apply_stimulus(vecs[i], i);

`ifdef FIFO_WR_OVERFLOW_EN
    check_output("overflow flag", woverflow, 1);
    check_output("overflow count", dut.wovf_cnt, 3);
`else
    check_output("overflow tied low", woverflow, 0);
`endif

    // wrap run: read pointer trails the write count by two entries
    do_reset();
    s0 = '0; s1 = '0; mwbin = '0; wr_total = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rptr_v = (wr_total >= 2) ? 4'(wr_total - 2) : 4'd0;
      rptr_gray = to_gray(rptr_v);
      winc = 1'b1;
      prev_gray = wptr_gray;
      @(posedge clk);
      #1;
      rqb = to_bin(s1);
      mwbin = mwbin + 4'd1;
      exp_lvl = mwbin - rqb;
      s1 = s0;
      s0 = rptr_gray;
      wr_total++;
      check_output($sformatf("wrap%0d wptr_gray", k), wptr_gray, to_gray(mwbin));
      check_output($sformatf("wrap%0d one-bit change", k), $countones(prev_gray ^ wptr_gray), 1);
      check_output($sformatf("wrap%0d wfull", k), wfull, 0);
      check_output($sformatf("wrap%0d wlevel", k), wlevel, exp_lvl);
      check_output($sformatf("wrap%0d walmost_full", k), walmost_full, (exp_lvl >= 4'd6) ? 1 : 0);
      check_output($sformatf("wrap%0d waddr", k), waddr, mwbin[2:0]);
    end

    // async reset in the middle of a cycle at level 5
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      winc = 1'b1;
    end
    @(negedge clk);
    winc = 1'b0;
    #1;
    check_output("pre-reset wlevel", wlevel, 5);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("async waddr", waddr, 0);
    check_output("async wptr_gray", wptr_gray, 0);
    check_output("async wfull", wfull, 0);
    check_output("async walmost_full", walmost_full, 0);
    check_output("async wlevel", wlevel, 0);
    check_output("async woverflow", woverflow, 0);
    check_output("async write_en", write_en, 0);
    @(negedge clk);
    rst = 1'b1;
    winc = 1'b1;
    #1;
    check_output("post-reset waddr", waddr, 0);
    check_output("post-reset write_en", write_en, 1);
    @(posedge clk);
    #1;
    check_output("post-reset next waddr", waddr, 1);
    check_output("post-reset wlevel", wlevel, 1);
    @(negedge clk);
    winc = 1'b0;

    // depth-4 instance with almost-full threshold of one
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      winc2 = 1'b1;
      #1;
      check_output($sformatf("small%0d write_en", k), write_en2, (k <= 4) ? 1 : 0);
      @(posedge clk);
      #1;
      check_output($sformatf("small%0d wlevel", k), wlevel2, (k <= 4) ? k : 4);
      check_output($sformatf("small%0d walmost_full", k), walmost_full2, 1);
      check_output($sformatf("small%0d wfull", k), wfull2, (k >= 4) ? 1 : 0);
      check_output($sformatf("small%0d waddr", k), waddr2, (k <= 4) ? (k % 4) : 0);
    end
    @(negedge clk);
    winc2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
